aes_core_arbiter: RTL

Shares one aes_top core between NUM_REQ independent requesters, for example several in-FIFO controllers or DMA channels. Requests are granted round-robin. Each requester gets a private key slot. Before an ENCRYPT, the block reloads the core key schedule with a replayed SET_KEY whenever the currently loaded key belongs to a different requester. It sits between the per-channel controllers and the aes_top core.

---
 rtl/aes_core_arbiter_pkg.sv | 12 +
 rtl/aes_core_arbiter_rr_arbiter.sv | 32 +++
 rtl/aes_core_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/aes_core_arbiter_pkg.sv
// Shared AES core command and bus width definitions.
// Imported by the arbiter top and its testbench.
package aes_core_arbiter_pkg;

    localparam int WORD_S = 32;
    localparam int BLK_S  = 128;
    localparam int KEY_S  = 128;

    localparam logic [WORD_S-1:0] CMD_ENCRYPT = 32'h0000_0001;
    localparam logic [WORD_S-1:0] CMD_SET_KEY = 32'h0000_0002;

endpackage

// File: rtl/aes_core_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first
// request found searching cyclically from ptr+1.
// Ports: req (requests), ptr (last grant), grant (one-hot), index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    int   j;
    logic found;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core among NUM_REQ requesters, round-robin, with a
// private key slot per requester and SET_KEY replay on owner change.
// Ports: req_* (per-requester valid/ready/cmd/data), rsp_* (response
// handshake), core_* (start pulse, operands, result, done pulse).
module aes_core_arbiter
    import aes_core_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*WORD_S-1:0] req_cmd,
    input  logic [NUM_REQ*BLK_S-1:0]  req_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_err,
    output logic [BLK_S-1:0]          rsp_data,
    output logic                      core_en,
    output logic [WORD_S-1:0]         core_cmd,
    output logic [KEY_S-1:0]          core_key,
    output logic [BLK_S-1:0]          core_plaintext,
    input  logic [BLK_S-1:0]          core_ciphertext,
    input  logic                      core_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_RELOAD,
        S_RELOAD_WAIT,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t state, state_next;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cur_id;
    logic [WORD_S-1:0]  cur_cmd;
    logic [BLK_S-1:0]   cur_data;
    logic [KEY_S-1:0]   key_slot [NUM_REQ];
    logic [NUM_REQ-1:0] key_vld;
    logic [ID_W-1:0]    owner;
    logic               owner_vld;
    logic [SW-1:0]      slot;
    logic               is_set;
    logic               is_enc;
    logic               hit;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (gnt_idx)
    );

    assign slot   = cur_id[SW-1:0];
    assign is_set = (cur_cmd == CMD_SET_KEY);
    assign is_enc = (cur_cmd == CMD_ENCRYPT);
    assign hit    = owner_vld && (owner == cur_id);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        core_en    = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = grant;
                if (|req_valid) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_set)              state_next = S_ISSUE;
                else if (!is_enc)        state_next = S_RESP;
                else if (!key_vld[slot]) state_next = S_RESP;
                else if (hit)            state_next = S_ISSUE;
                else                     state_next = S_RELOAD;
            end
            S_RELOAD: begin
                core_en    = 1'b1;
                state_next = S_RELOAD_WAIT;
            end
            S_RELOAD_WAIT: begin
                if (core_done) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                core_en    = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Core operands are loaded on entry to RELOAD/ISSUE and then left
    // alone, so they stay stable until the matching core_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr         <= ID_W'(NUM_REQ - 1);
            cur_id         <= '0;
            cur_cmd        <= '0;
            cur_data       <= '0;
            key_vld        <= '0;
            owner          <= '0;
            owner_vld      <= 1'b0;
            rsp_id         <= '0;
            rsp_err        <= 1'b0;
            rsp_data       <= '0;
            core_cmd       <= '0;
            core_key       <= '0;
            core_plaintext <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        cur_id   <= gnt_idx;
                        rr_ptr   <= gnt_idx;
                        cur_cmd  <= req_cmd[int'(gnt_idx)*WORD_S +: WORD_S];
                        cur_data <= req_data[int'(gnt_idx)*BLK_S +: BLK_S];
                    end
                end
                S_DECODE: begin
                    rsp_id <= cur_id;
                    if (is_set) begin
                        key_slot[slot] <= cur_data;
                        key_vld[slot]  <= 1'b1;
                        core_cmd       <= CMD_SET_KEY;
                        core_key       <= cur_data;
                        core_plaintext <= '0;
                    end else if (!is_enc || !key_vld[slot]) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end else if (hit) begin
                        core_cmd       <= CMD_ENCRYPT;
                        core_key       <= key_slot[slot];
                        core_plaintext <= cur_data;
                    end else begin
                        core_cmd       <= CMD_SET_KEY;
                        core_key       <= key_slot[slot];
                        core_plaintext <= '0;
                    end
                end
                S_RELOAD_WAIT: begin
                    if (core_done) begin
                        owner          <= cur_id;
                        owner_vld      <= 1'b1;
                        core_cmd       <= CMD_ENCRYPT;
                        core_plaintext <= cur_data;
                    end
                end
                S_WAIT: begin
                    if (core_done) begin
                        rsp_err  <= 1'b0;
                        rsp_data <= is_enc ? core_ciphertext : '0;
                        if (is_set) begin
                            owner     <= cur_id;
                            owner_vld <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
